// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, byte-lane unified memory between instruction fetch and the
// load/store unit, encodes store lanes and aligns/extends load data on the response path.
module mem_port_arbiter #(
    parameter int WORD_AW    = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               io_if_req,
    input  logic [63:0]        io_if_addr,
    output logic               io_if_gnt,
    output logic               io_if_rvalid,
    output logic [31:0]        io_if_inst_0,
    output logic [31:0]        io_if_inst_1,

    input  logic               io_lsu_req,
    input  logic               io_lsu_we,
    input  logic [63:0]        io_lsu_addr,
    input  logic [31:0]        io_lsu_wdata,
    input  logic [2:0]         io_lsu_func3,
    output logic               io_lsu_gnt,
    output logic               io_lsu_rvalid,
    output logic [31:0]        io_lsu_rdata,
    output logic               io_lsu_err,

    output logic               mem_en,
    output logic [WORD_AW-1:0] mem_addr0,
    output logic [WORD_AW-1:0] mem_addr1,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata0,
    input  logic [31:0]        mem_rdata1
);

    localparam int              SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // Arbitration and starvation counter
    // ------------------------------------------------------------------
    logic [SC_W-1:0] starve_cnt;
    logic            force_if;
    logic            if_gnt;
    logic            lsu_gnt;

    assign force_if = io_if_req && (starve_cnt == STARVE_LIM);
    assign if_gnt   = !reset && io_if_req && (force_if || !io_lsu_req);
    assign lsu_gnt  = !reset && io_lsu_req && !force_if;

    assign io_if_gnt  = if_gnt;
    assign io_lsu_gnt = lsu_gnt;

    // NOTE: sequential state is always updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (io_if_req && !if_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // LSU request decode: legality, alignment, lane enables, write data
    // ------------------------------------------------------------------
    logic [1:0]  lsu_off;
    logic        f3_legal;
    logic        misaligned;
    logic        lsu_err_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign lsu_off = io_lsu_addr[1:0];

    // NOTE: every output of this block gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = io_lsu_wdata;
        case (io_lsu_func3)
            F3_B: begin
                f3_legal = 1'b1;
                be_c     = 4'b0001 << lsu_off;
                wdata_c  = {4{io_lsu_wdata[7:0]}};
            end
            F3_H: begin
                f3_legal   = 1'b1;
                misaligned = lsu_off[0];
                be_c       = 4'b0011 << lsu_off;
                wdata_c    = {2{io_lsu_wdata[15:0]}};
            end
            F3_W: begin
                f3_legal   = 1'b1;
                misaligned = (lsu_off != 2'b00);
                be_c       = 4'b1111;
            end
            F3_BU: begin
                f3_legal = !io_lsu_we;
            end
            F3_HU: begin
                f3_legal   = !io_lsu_we;
                misaligned = lsu_off[0];
            end
            default: begin
                f3_legal = 1'b0;
            end
        endcase
    end

    assign lsu_err_c = !f3_legal || misaligned;

    // ------------------------------------------------------------------
    // Memory drive: an erroneous LSU access is granted but never reaches the array
    // ------------------------------------------------------------------
    logic [WORD_AW-1:0] word_sel;

    assign word_sel  = if_gnt ? io_if_addr[WORD_AW+1:2] : io_lsu_addr[WORD_AW+1:2];
    assign mem_en    = if_gnt || (lsu_gnt && !lsu_err_c);
    assign mem_addr0 = word_sel;
    assign mem_addr1 = word_sel + WORD_AW'(1);
    assign mem_be    = (lsu_gnt && io_lsu_we && !lsu_err_c) ? be_c : 4'b0000;
    assign mem_wdata = wdata_c;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{io_if_addr[63:WORD_AW+2], io_if_addr[1:0],
                                io_lsu_addr[63:WORD_AW+2]};

    // ------------------------------------------------------------------
    // Response stage: attributes captured at grant, data arrives with the memory
    // ------------------------------------------------------------------
    logic       if_pend;
    logic       lsu_pend;
    logic       resp_we;
    logic       resp_err;
    logic [1:0] resp_off;
    logic [2:0] resp_f3;

    always_ff @(posedge clock) begin
        if (reset) begin
            if_pend  <= 1'b0;
            lsu_pend <= 1'b0;
            resp_we  <= 1'b0;
            resp_err <= 1'b0;
            resp_off <= 2'b00;
            resp_f3  <= 3'b000;
        end else begin
            if_pend  <= if_gnt;
            lsu_pend <= lsu_gnt;
            if (lsu_gnt) begin
                resp_we  <= io_lsu_we;
                resp_err <= lsu_err_c;
                resp_off <= lsu_off;
                resp_f3  <= io_lsu_func3;
            end
        end
    end

    // A response pending across a reset edge is suppressed here so it never escapes.
    assign io_if_rvalid  = if_pend && !reset;
    assign io_lsu_rvalid = lsu_pend && !reset;

    logic [31:0] shifted;
    logic [31:0] load_c;

    always_comb begin
        shifted = mem_rdata0 >> {resp_off, 3'b000};
        load_c  = '0;
        if (!resp_we && !resp_err) begin
            case (resp_f3)
                F3_B:    load_c = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    load_c = {{16{shifted[15]}}, shifted[15:0]};
                F3_W:    load_c = shifted;
                F3_BU:   load_c = {24'h0, shifted[7:0]};
                F3_HU:   load_c = {16'h0, shifted[15:0]};
                default: load_c = '0;
            endcase
        end
    end

    // Hold registers keep the last delivered data visible between responses.
    logic [31:0] inst0_q;
    logic [31:0] inst1_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inst0_q <= '0;
            inst1_q <= '0;
            rdata_q <= '0;
        end else begin
            if (io_if_rvalid) begin
                inst0_q <= mem_rdata0;
                inst1_q <= mem_rdata1;
            end
            if (io_lsu_rvalid) begin
                rdata_q <= load_c;
            end
        end
    end

    assign io_if_inst_0 = io_if_rvalid  ? mem_rdata0 : (reset ? '0 : inst0_q);
    assign io_if_inst_1 = io_if_rvalid  ? mem_rdata1 : (reset ? '0 : inst1_q);
    assign io_lsu_rdata = io_lsu_rvalid ? load_c     : (reset ? '0 : rdata_q);
    assign io_lsu_err   = io_lsu_rvalid && resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized stream
// checked against a word-array reference memory and a denial-count arbitration model.
module tb_mem_port_arbiter;

    localparam int WORD_AW    = 14;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << WORD_AW;

    logic               clock = 1'b0;
    logic               reset;
    logic               io_if_req;
    logic [63:0]        io_if_addr;
    logic               io_if_gnt;
    logic               io_if_rvalid;
    logic [31:0]        io_if_inst_0;
    logic [31:0]        io_if_inst_1;
    logic               io_lsu_req;
    logic               io_lsu_we;
    logic [63:0]        io_lsu_addr;
    logic [31:0]        io_lsu_wdata;
    logic [2:0]         io_lsu_func3;
    logic               io_lsu_gnt;
    logic               io_lsu_rvalid;
    logic [31:0]        io_lsu_rdata;
    logic               io_lsu_err;
    logic               mem_en;
    logic [WORD_AW-1:0] mem_addr0;
    logic [WORD_AW-1:0] mem_addr1;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata0;
    logic [31:0]        mem_rdata1;

    logic [31:0]        mem     [DEPTH];
    logic [31:0]        ref_mem [DEPTH];
    logic               bd_fill = 1'b0;
    logic               bd_we   = 1'b0;
    logic [WORD_AW-1:0] bd_addr = '0;
    logic [31:0]        bd_data = '0;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.WORD_AW(WORD_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset(reset),
        .io_if_req(io_if_req), .io_if_addr(io_if_addr), .io_if_gnt(io_if_gnt),
        .io_if_rvalid(io_if_rvalid), .io_if_inst_0(io_if_inst_0), .io_if_inst_1(io_if_inst_1),
        .io_lsu_req(io_lsu_req), .io_lsu_we(io_lsu_we), .io_lsu_addr(io_lsu_addr),
        .io_lsu_wdata(io_lsu_wdata), .io_lsu_func3(io_lsu_func3), .io_lsu_gnt(io_lsu_gnt),
        .io_lsu_rvalid(io_lsu_rvalid), .io_lsu_rdata(io_lsu_rdata), .io_lsu_err(io_lsu_err),
        .mem_en(mem_en), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] fill_word(int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Memory array with one-cycle registered read and a backdoor for preloading.
    always @(posedge clock) begin
        if (bd_fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill_word(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr0][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata0 <= mem[mem_addr0];
            mem_rdata1 <= mem[mem_addr1];
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_of(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(logic we, logic [1:0] off, logic [2:0] f3);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((int'(off) % size_of(f3)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] word, logic [1:0] off, logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * int'(off));
        case (f3)
            3'd0:    return v[7]  ? ((v & 32'hFF)   | 32'hFFFF_FF00) : (v & 32'hFF);
            3'd1:    return v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            3'd2:    return word;
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] off, logic [2:0] f3);
        int m;
        m = ((1 << size_of(f3)) - 1) << off;
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] wd, logic [2:0] f3);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
        return r;
    endfunction

    task automatic apply_store(int w, logic [1:0] off, logic [2:0] f3, logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] rep;
        be  = ref_be(off, f3);
        rep = ref_wdata(wd, f3);
        for (int i = 0; i < 4; i++) if (be[i]) ref_mem[w][8*i +: 8] = rep[8*i +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        io_if_req = 1'b0; io_if_addr = '0;
        io_lsu_req = 1'b0; io_lsu_we = 1'b0; io_lsu_addr = '0; io_lsu_wdata = '0; io_lsu_func3 = '0;
    endtask

    task automatic lsu_drive(logic we, logic [63:0] addr, logic [31:0] wd, logic [2:0] f3);
        io_lsu_req = 1'b1; io_lsu_we = we; io_lsu_addr = addr; io_lsu_wdata = wd; io_lsu_func3 = f3;
    endtask

    task automatic bd_write(int w, logic [31:0] d);
        bd_we = 1'b1; bd_addr = WORD_AW'(w); bd_data = d; ref_mem[w] = d;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        io_if_req = 1'b1; io_if_addr = 64'h100;
        lsu_drive(1'b1, 64'h200, 32'hFFFF_FFFF, 3'd2);
        @(negedge clock);
        tests++; if (io_if_gnt !== 1'b0) begin fails++; $display("FAIL rst_if_gnt got=%b exp=0", io_if_gnt); end
        tests++; if (io_lsu_gnt !== 1'b0) begin fails++; $display("FAIL rst_lsu_gnt got=%b exp=0", io_lsu_gnt); end
        tests++; if ({mem_en, mem_be} !== 5'b0) begin fails++; $display("FAIL rst_mem_en_be got=%b exp=0", {mem_en, mem_be}); end
        tests++; if ({io_if_rvalid, io_lsu_rvalid, io_lsu_err} !== 3'b0) begin fails++; $display("FAIL rst_valid_err got=%b exp=000", {io_if_rvalid, io_lsu_rvalid, io_lsu_err}); end
        tests++; if ({io_if_inst_0, io_if_inst_1, io_lsu_rdata} !== 96'h0) begin fails++; $display("FAIL rst_data got=%h exp=0", {io_if_inst_0, io_if_inst_1, io_lsu_rdata}); end
        @(posedge clock); #1;
        reset = 1'b0; idle();
        @(posedge clock); #1;
    endtask

    task automatic test_if_fetch();
        bd_write(32'h40, 32'h0000_0013);
        bd_write(32'h41, 32'h0010_0093);
        io_if_req = 1'b1; io_if_addr = 64'h100;
        @(negedge clock);
        tests++; if ({io_if_gnt, io_lsu_gnt, mem_en} !== 3'b101) begin fails++; $display("FAIL fetch_gnt got=%b exp=101", {io_if_gnt, io_lsu_gnt, mem_en}); end
        tests++; if (mem_addr0 !== 14'h40 || mem_addr1 !== 14'h41) begin fails++; $display("FAIL fetch_addr got=%h/%h exp=40/41", mem_addr0, mem_addr1); end
        tests++; if (mem_be !== 4'b0) begin fails++; $display("FAIL fetch_be got=%b exp=0000", mem_be); end
        @(posedge clock); #1; idle();
        @(negedge clock);
        tests++; if ({io_if_rvalid, io_lsu_rvalid} !== 2'b10) begin fails++; $display("FAIL fetch_rvalid got=%b exp=10", {io_if_rvalid, io_lsu_rvalid}); end
        tests++; if (io_if_inst_0 !== 32'h0000_0013) begin fails++; $display("FAIL fetch_inst0 got=%h exp=00000013", io_if_inst_0); end
        tests++; if (io_if_inst_1 !== 32'h0010_0093) begin fails++; $display("FAIL fetch_inst1 got=%h exp=00100093", io_if_inst_1); end
        @(posedge clock); #1;
        @(negedge clock);
        tests++; if (io_if_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_pulse got=%b exp=0", io_if_rvalid); end
        @(posedge clock); #1;
        io_if_req = 1'b1; io_if_addr = 64'((DEPTH - 1) * 4);
        @(negedge clock);
        tests++; if (mem_addr0 !== 14'h3FFF || mem_addr1 !== 14'h0) begin fails++; $display("FAIL wrap_addr got=%h/%h exp=3fff/0", mem_addr0, mem_addr1); end
        @(posedge clock); #1; idle();
        @(negedge clock);
        tests++; if (io_if_inst_0 !== ref_mem[DEPTH-1] || io_if_inst_1 !== ref_mem[0]) begin fails++; $display("FAIL wrap_inst got=%h/%h exp=%h/%h", io_if_inst_0, io_if_inst_1, ref_mem[DEPTH-1], ref_mem[0]); end
        @(posedge clock); #1;
    endtask

    task automatic test_store_lanes();
        logic [63:0] addr   [2] = '{64'h203, 64'h202};
        logic [31:0] wd     [2] = '{32'hAB, 32'h1234};
        logic [2:0]  f3     [2] = '{3'd0, 3'd1};
        logic [3:0]  exp_be [2] = '{4'b1000, 4'b1100};
        logic [31:0] exp_wd [2] = '{32'hABAB_ABAB, 32'h1234_1234};
        for (int k = 0; k < 2; k++) begin
            lsu_drive(1'b1, addr[k], wd[k], f3[k]);
            @(negedge clock);
            tests++; if ({io_lsu_gnt, mem_en, mem_addr0} !== {2'b11, 14'h80}) begin fails++; $display("FAIL st%0d_gnt got=%b/%b/%h exp=1/1/80", k, io_lsu_gnt, mem_en, mem_addr0); end
            tests++; if (mem_be !== exp_be[k]) begin fails++; $display("FAIL st%0d_be got=%b exp=%b", k, mem_be, exp_be[k]); end
            tests++; if (mem_wdata !== exp_wd[k]) begin fails++; $display("FAIL st%0d_wdata got=%h exp=%h", k, mem_wdata, exp_wd[k]); end
            apply_store(32'h80, addr[k][1:0], f3[k], wd[k]);
            @(posedge clock); #1; idle();
            @(negedge clock);
            tests++; if ({io_lsu_rvalid, io_lsu_err, io_lsu_rdata} !== {2'b10, 32'h0}) begin fails++; $display("FAIL st%0d_resp got=%b/%b/%h exp=1/0/0", k, io_lsu_rvalid, io_lsu_err, io_lsu_rdata); end
            @(posedge clock); #1;
        end
        tests++; if (mem[32'h80] !== ref_mem[32'h80]) begin fails++; $display("FAIL st_mem got=%h exp=%h", mem[32'h80], ref_mem[32'h80]); end
    endtask

    task automatic test_load_extend();
        logic [63:0] addr [5] = '{64'h301, 64'h302, 64'h303, 64'h302, 64'h302};
        logic [2:0]  f3   [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] exp  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        bd_write(32'hC0, 32'h80FF_7F01);
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) lsu_drive(1'b0, addr[k], 32'h0, f3[k]);
            else idle();
            @(negedge clock);
            if (k < 5) begin
                tests++; if ({io_lsu_gnt, mem_en, mem_be} !== 6'b110000) begin fails++; $display("FAIL ld%0d_gnt got=%b/%b/%b exp=1/1/0000", k, io_lsu_gnt, mem_en, mem_be); end
            end
            if (k > 0) begin
                tests++; if ({io_lsu_rvalid, io_lsu_err} !== 2'b10) begin fails++; $display("FAIL ld%0d_rvalid got=%b/%b exp=1/0", k-1, io_lsu_rvalid, io_lsu_err); end
                tests++; if (io_lsu_rdata !== exp[k-1]) begin fails++; $display("FAIL ld%0d_rdata got=%h exp=%h", k-1, io_lsu_rdata, exp[k-1]); end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_errors();
        logic        we   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] addr [4] = '{64'h401, 64'h400, 64'h201, 64'h200};
        logic [2:0]  f3   [4] = '{3'd2, 3'd3, 3'd1, 3'd4};
        for (int k = 0; k < 4; k++) begin
            lsu_drive(we[k], addr[k], 32'hDEAD_BEEF, f3[k]);
            @(negedge clock);
            tests++; if ({io_lsu_gnt, mem_en, mem_be} !== 6'b100000) begin fails++; $display("FAIL err%0d_drive got=%b/%b/%b exp=1/0/0000", k, io_lsu_gnt, mem_en, mem_be); end
            @(posedge clock); #1; idle();
            @(negedge clock);
            tests++; if ({io_lsu_rvalid, io_lsu_err, io_lsu_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL err%0d_resp got=%b/%b/%h exp=1/1/0", k, io_lsu_rvalid, io_lsu_err, io_lsu_rdata); end
            @(posedge clock); #1;
        end
        tests++; if (mem[32'h100] !== ref_mem[32'h100] || mem[32'h80] !== ref_mem[32'h80]) begin fails++; $display("FAIL err_nowrite got=%h/%h exp=%h/%h", mem[32'h100], mem[32'h80], ref_mem[32'h100], ref_mem[32'h80]); end
    endtask

    task automatic test_starvation();
        logic exp_if;
        logic prev_if = 1'b0;
        io_if_req = 1'b1; io_if_addr = 64'h100;
        lsu_drive(1'b0, 64'h300, 32'h0, 3'd2);
        for (int k = 0; k <= 15; k++) begin
            if (k == 15) idle();
            @(negedge clock);
            exp_if = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
            if (k < 15) begin
                tests++; if ({io_if_gnt, io_lsu_gnt} !== {exp_if, !exp_if}) begin fails++; $display("FAIL starve%0d_gnt got=%b exp=%b", k, {io_if_gnt, io_lsu_gnt}, {exp_if, !exp_if}); end
            end
            if (k > 0) begin
                tests++; if ({io_if_rvalid, io_lsu_rvalid} !== {prev_if, !prev_if}) begin fails++; $display("FAIL starve%0d_order got=%b exp=%b", k, {io_if_rvalid, io_lsu_rvalid}, {prev_if, !prev_if}); end
                if (prev_if) begin
                    tests++; if (io_if_inst_0 !== ref_mem[32'h40]) begin fails++; $display("FAIL starve%0d_inst got=%h exp=%h", k, io_if_inst_0, ref_mem[32'h40]); end
                end else begin
                    tests++; if (io_lsu_rdata !== 32'h80FF_7F01) begin fails++; $display("FAIL starve%0d_rdata got=%h exp=80ff7f01", k, io_lsu_rdata); end
                end
            end
            prev_if = exp_if;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_random();
        int          denied = 0;
        int          pend   = 0;
        logic [31:0] e_inst0 = '0, e_inst1 = '0, e_rdata = '0;
        logic        e_err = 1'b0;
        logic        g_if, g_lsu;
        int          w;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!io_if_req && $urandom_range(0, 2) != 0) begin
                io_if_req  = 1'b1;
                io_if_addr = ($urandom_range(0, 7) == 0) ? 64'((DEPTH - 1) * 4) : 64'($urandom_range(0, 255));
            end
            if (!io_lsu_req && $urandom_range(0, 2) != 0)
                lsu_drive(1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)), $urandom, 3'($urandom_range(0, 7)));
            @(negedge clock);
            g_if  = io_if_req && (denied >= STARVE_MAX || !io_lsu_req);
            g_lsu = io_lsu_req && !(io_if_req && denied >= STARVE_MAX);
            tests++; if ({io_if_gnt, io_lsu_gnt} !== {g_if, g_lsu}) begin fails++; $display("FAIL rnd%0d_gnt got=%b exp=%b", cyc, {io_if_gnt, io_lsu_gnt}, {g_if, g_lsu}); end
            if (pend == 0) begin
                tests++; if ({io_if_rvalid, io_lsu_rvalid} !== 2'b00) begin fails++; $display("FAIL rnd%0d_idle got=%b exp=00", cyc, {io_if_rvalid, io_lsu_rvalid}); end
            end else if (pend == 1) begin
                tests++; if ({io_if_rvalid, io_lsu_rvalid, io_if_inst_0, io_if_inst_1} !== {2'b10, e_inst0, e_inst1}) begin fails++; $display("FAIL rnd%0d_if got=%b/%h/%h exp=10/%h/%h", cyc, {io_if_rvalid, io_lsu_rvalid}, io_if_inst_0, io_if_inst_1, e_inst0, e_inst1); end
            end else begin
                tests++; if ({io_if_rvalid, io_lsu_rvalid, io_lsu_err, io_lsu_rdata} !== {2'b01, e_err, e_rdata}) begin fails++; $display("FAIL rnd%0d_lsu got=%b/%b/%h exp=01/%b/%h", cyc, {io_if_rvalid, io_lsu_rvalid}, io_lsu_err, io_lsu_rdata, e_err, e_rdata); end
            end
            pend = 0;
            if (g_if) begin
                pend    = 1;
                w       = int'(io_if_addr[WORD_AW+1:2]);
                e_inst0 = ref_mem[w];
                e_inst1 = ref_mem[(w + 1) % DEPTH];
                tests++; if ({mem_en, mem_be, 32'(mem_addr0), 32'(mem_addr1)} !== {5'b10000, 32'(w), 32'((w + 1) % DEPTH)}) begin fails++; $display("FAIL rnd%0d_fetch_drive got=%b/%b/%h/%h exp word %h", cyc, mem_en, mem_be, mem_addr0, mem_addr1, w); end
            end
            if (g_lsu) begin
                pend    = 2;
                w       = int'(io_lsu_addr[WORD_AW+1:2]);
                e_err   = ref_err(io_lsu_we, io_lsu_addr[1:0], io_lsu_func3);
                e_rdata = (e_err || io_lsu_we) ? 32'h0 : ref_load(ref_mem[w], io_lsu_addr[1:0], io_lsu_func3);
                tests++; if ({mem_en, mem_be} !== {!e_err, (io_lsu_we && !e_err) ? ref_be(io_lsu_addr[1:0], io_lsu_func3) : 4'b0}) begin fails++; $display("FAIL rnd%0d_lsu_drive got=%b/%b we=%b f3=%0d addr=%h", cyc, mem_en, mem_be, io_lsu_we, io_lsu_func3, io_lsu_addr); end
                if (io_lsu_we && !e_err) begin
                    tests++; if (mem_wdata !== ref_wdata(io_lsu_wdata, io_lsu_func3)) begin fails++; $display("FAIL rnd%0d_wdata got=%h exp=%h", cyc, mem_wdata, ref_wdata(io_lsu_wdata, io_lsu_func3)); end
                    apply_store(w, io_lsu_addr[1:0], io_lsu_func3, io_lsu_wdata);
                end
            end
            denied = (io_if_req && !g_if) ? ((denied < STARVE_MAX) ? denied + 1 : STARVE_MAX) : 0;
            @(posedge clock); #1;
            if (g_if) io_if_req = 1'b0;
            if (g_lsu) io_lsu_req = 1'b0;
        end
        idle();
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset_midflight();
        lsu_drive(1'b0, 64'h301, 32'h0, 3'd0);
        @(negedge clock);
        tests++; if (io_lsu_gnt !== 1'b1) begin fails++; $display("FAIL mid_gnt got=%b exp=1", io_lsu_gnt); end
        @(posedge clock); #1;
        reset = 1'b1; idle(); io_if_req = 1'b1; io_if_addr = 64'h100;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            tests++; if ({io_if_rvalid, io_lsu_rvalid, io_lsu_err, io_if_gnt, io_lsu_gnt, mem_en, mem_be} !== 10'b0) begin fails++; $display("FAIL mid_rst%0d_ctl got=%b exp=0", k, {io_if_rvalid, io_lsu_rvalid, io_lsu_err, io_if_gnt, io_lsu_gnt, mem_en, mem_be}); end
            tests++; if ({io_if_inst_0, io_if_inst_1, io_lsu_rdata} !== 96'h0) begin fails++; $display("FAIL mid_rst%0d_data got=%h exp=0", k, {io_if_inst_0, io_if_inst_1, io_lsu_rdata}); end
            @(posedge clock); #1;
        end
        reset = 1'b0; idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests++; if ({io_if_rvalid, io_lsu_rvalid} !== 2'b00) begin fails++; $display("FAIL mid_post%0d_rvalid got=%b exp=00", k, {io_if_rvalid, io_lsu_rvalid}); end
            @(posedge clock); #1;
        end
        lsu_drive(1'b0, 64'h301, 32'h0, 3'd0);
        @(negedge clock);
        tests++; if ({io_lsu_gnt, mem_en} !== 2'b11) begin fails++; $display("FAIL mid_again_gnt got=%b exp=11", {io_lsu_gnt, mem_en}); end
        @(posedge clock); #1; idle();
        @(negedge clock);
        tests++; if ({io_lsu_rvalid, io_lsu_err, io_lsu_rdata} !== {2'b10, 32'h7F}) begin fails++; $display("FAIL mid_again_resp got=%b/%b/%h exp=1/0/7f", io_lsu_rvalid, io_lsu_err, io_lsu_rdata); end
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_word(i);
        bd_fill = 1'b1;
        @(posedge clock); #1;
        bd_fill = 1'b0;
        test_reset();
        test_if_fetch();
        test_store_lanes();
        test_load_extend();
        test_errors();
        test_starvation();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
